// File: rtl/stopwatch_ctrl_if.sv
// Command/status bundle between the button front end and the stopwatch
// controller. The master side issues single-cycle command pulses; the slave
// side returns the packed BCD display value and status flags.
interface stopwatch_ctrl_if #(
  parameter int NDIG = 4
);
  logic              start_stop;
  logic              clear;
  logic              lap;
  logic [4*NDIG-1:0] digits;
  logic              running;
  logic              overflow;

  modport master (
    output start_stop, clear, lap,
    input  digits, running, overflow
  );

  modport slave (
    input  start_stop, clear, lap,
    output digits, running, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap stopwatch controller: prescaler, cascaded BCD digit chain
// with single-cycle ripple carry, and a four-state mode FSM.
// Optional build macro STOPWATCH_AUTOCLR_EN: a start from IDLE, or a resume
// from PAUSE after an overflow, restarts the count from zero.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int NDIG     = 4
) (
  input  logic            clk,
  input  logic            rst,
  stopwatch_ctrl_if.slave bus
);

  localparam int DW = 4 * NDIG;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [DW-1:0]   live_q, live_d;
  logic [DW-1:0]   lap_q, lap_d;
  logic [DW-1:0]   digits_q, digits_d;
  logic            running_q, running_d;
  logic            ovf_q, ovf_d;

  logic            cmd_clr_s, cmd_ss_s, cmd_lap_s;
  logic            counting_s, tick_s, wrap_s;
  logic            zero_s, capture_s;
  logic [DW-1:0]   live_inc_s;

  // Increment the whole digit chain by one; a 9 rolls to 0 and carries,
  // an out-of-range digit is forced to 0 and absorbs the carry.
  function automatic logic [DW-1:0] bcd_chain_inc(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      if (carry) begin
        if (v[4*k +: 4] == 4'd9) begin
          r[4*k +: 4] = 4'd0;
          carry       = 1'b1;
        end else if (v[4*k +: 4] > 4'd9) begin
          r[4*k +: 4] = 4'd0;
          carry       = 1'b0;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        r[4*k +: 4] = v[4*k +: 4];
      end
    end
    return r;
  endfunction

  // True when every digit of the chain holds 9.
  function automatic logic bcd_all_nines(input logic [DW-1:0] v);
    logic all9;
    all9 = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      if (v[4*k +: 4] != 4'd9) begin
        all9 = 1'b0;
      end else begin
        all9 = all9;
      end
    end
    return all9;
  endfunction

  // Resolve simultaneous command pulses: clear beats start_stop beats lap.
  always_comb begin
    cmd_clr_s = bus.clear;
    cmd_ss_s  = bus.start_stop & ~bus.clear;
    cmd_lap_s = bus.lap & ~bus.start_stop & ~bus.clear;
  end

  // Count tick: last prescaler step while the clock is running.
  always_comb begin
    counting_s = (state_q == ST_RUN) || (state_q == ST_LAP);
    tick_s     = counting_s && (presc_q == PRESC_LAST);
    live_inc_s = bcd_chain_inc(live_q);
    wrap_s     = tick_s && bcd_all_nines(live_q);
  end

  // Mode FSM next state plus the zero/capture strobes it raises.
  always_comb begin
    state_d   = state_q;
    zero_s    = 1'b0;
    capture_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_ss_s) begin
          state_d = ST_RUN;
`ifdef STOPWATCH_AUTOCLR_EN
          zero_s  = 1'b1;
`else
          zero_s  = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cmd_ss_s) begin
          state_d = ST_PAUSE;
        end else if (cmd_lap_s) begin
          state_d   = ST_LAP;
          capture_s = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LAP: begin
        if (cmd_ss_s) begin
          state_d = ST_PAUSE;
        end else if (cmd_lap_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_LAP;
        end
      end
      ST_PAUSE: begin
        if (cmd_clr_s) begin
          state_d = ST_IDLE;
          zero_s  = 1'b1;
        end else if (cmd_ss_s) begin
          state_d = ST_RUN;
`ifdef STOPWATCH_AUTOCLR_EN
          zero_s  = ovf_q;
`else
          zero_s  = 1'b0;
`endif
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: prescaler, live digits, lap latch, flags, display.
  always_comb begin
    presc_d = presc_q;
    live_d  = live_q;
    ovf_d   = ovf_q;
    lap_d   = lap_q;
    if (zero_s) begin
      presc_d = {PW{1'b0}};
      live_d  = {DW{1'b0}};
      ovf_d   = 1'b0;
    end else if (counting_s) begin
      if (tick_s) begin
        presc_d = {PW{1'b0}};
        live_d  = live_inc_s;
        ovf_d   = ovf_q | wrap_s;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = presc_q;
    end
    if (capture_s) begin
      lap_d = live_q;
    end else begin
      lap_d = lap_q;
    end
    if (state_d == ST_LAP) begin
      digits_d = lap_d;
    end else begin
      digits_d = live_d;
    end
    running_d = (state_d == ST_RUN) || (state_d == ST_LAP);
  end

  // State and output registers, cleared asynchronously by rst low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= {PW{1'b0}};
      live_q    <= {DW{1'b0}};
      lap_q     <= {DW{1'b0}};
      digits_q  <= {DW{1'b0}};
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      live_q    <= live_d;
      lap_q     <= lap_d;
      digits_q  <= digits_d;
      running_q <= running_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.digits   = digits_q;
  assign bus.running  = running_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl (TICK_DIV=4, NDIG=4). A small integer
// model predicts the outputs for every clock edge; predictions are queued
// when stimulus is applied and compared after the edge.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 4;
  localparam int NDIG     = 4;

  typedef struct {
    logic [15:0] digits;
    logic        running;
    logic        overflow;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   edge_n;

  exp_t sb_q[$];

  // model state: 0 idle, 1 run, 2 pause, 3 lap
  int   st_m;
  int   presc_m;
  int   cnt_m;
  int   latch_m;
  bit   ovf_m;

  stopwatch_ctrl_if #(.NDIG(NDIG)) bus ();

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .NDIG(NDIG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int v;
    v = n;
    r = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b expected %b (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    st_m = 0; presc_m = 0; cnt_m = 0; latch_m = 0; ovf_m = 1'b0;
  endtask

  // Predict the coming edge, then clock and compare against the prediction.
  task automatic step();
    exp_t e, o;
    bit counting, c_clr, c_ss, c_lap, zero, cap, tick;
    int nst;
    counting = (st_m == 1) || (st_m == 3);
    c_clr = bus.clear;
    c_ss  = bus.start_stop && !bus.clear;
    c_lap = bus.lap && !bus.start_stop && !bus.clear;
    tick  = counting && (presc_m == TICK_DIV - 1);
    nst = st_m; zero = 1'b0; cap = 1'b0;
    case (st_m)
      0: if (c_ss) begin
           nst = 1;
`ifdef STOPWATCH_AUTOCLR_EN
           zero = 1'b1;
`endif
         end
      1: if (c_ss) nst = 2; else if (c_lap) begin nst = 3; cap = 1'b1; end
      3: if (c_ss) nst = 2; else if (c_lap) nst = 1;
      2: if (c_clr) begin nst = 0; zero = 1'b1; end
         else if (c_ss) begin
           nst = 1;
`ifdef STOPWATCH_AUTOCLR_EN
           zero = ovf_m;
`endif
         end
      default: nst = 0;
    endcase
    if (cap) latch_m = cnt_m;
    if (zero) begin
      presc_m = 0; cnt_m = 0; ovf_m = 1'b0;
    end else if (counting) begin
      if (tick) begin
        presc_m = 0;
        if (cnt_m == 9999) begin cnt_m = 0; ovf_m = 1'b1; end
        else cnt_m = cnt_m + 1;
      end else begin
        presc_m = presc_m + 1;
      end
    end
    st_m = nst;
    e.digits   = (st_m == 3) ? to_bcd(latch_m) : to_bcd(cnt_m);
    e.running  = (st_m == 1) || (st_m == 3);
    e.overflow = ovf_m;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    edge_n++;
    o = sb_q.pop_front();
    chk16("sb_digits", bus.digits, o.digits);
    chk1("sb_running", bus.running, o.running);
    chk1("sb_overflow", bus.overflow, o.overflow);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse(input bit ss, input bit clr, input bit lp);
    bus.start_stop = ss; bus.clear = clr; bus.lap = lp;
    step();
    bus.start_stop = 1'b0; bus.clear = 1'b0; bus.lap = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; edge_n = 0;
    bus.start_stop = 1'b0; bus.clear = 1'b0; bus.lap = 1'b0;
    rst = 1'b0;
    model_reset();
    #12;
    chk16("rst_digits", bus.digits, 16'h0000);
    chk1("rst_running", bus.running, 1'b0);
    chk1("rst_overflow", bus.overflow, 1'b0);
    rst = 1'b1;
    run(3);

    // first run: basic ticks, carries, wrap
    pulse(1'b1, 1'b0, 1'b0);
    chk1("start_running", bus.running, 1'b1);
    run(3);
    chk16("pre_first_tick", bus.digits, 16'h0000);
    run(1);
    chk16("first_tick", bus.digits, 16'h0001);
    run(36);
    chk16("carry_0010", bus.digits, 16'h0010);
    run(356);
    chk16("at_0099", bus.digits, 16'h0099);
    run(4);
    chk16("carry_0100", bus.digits, 16'h0100);
    run(4);
    chk16("at_0101", bus.digits, 16'h0101);
    run(39595);
    chk16("at_9999", bus.digits, 16'h9999);
    chk1("no_ovf_yet", bus.overflow, 1'b0);
    run(1);
    chk16("wrap_digits", bus.digits, 16'h0000);
    chk1("wrap_overflow", bus.overflow, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    chk1("pause_running", bus.running, 1'b0);
    chk1("pause_ovf_kept", bus.overflow, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    chk16("clear_digits", bus.digits, 16'h0000);
    chk1("clear_overflow", bus.overflow, 1'b0);
    chk1("clear_running", bus.running, 1'b0);

    // lap freeze / release
    pulse(1'b1, 1'b0, 1'b0);
    run(48);
    chk16("at_0012", bus.digits, 16'h0012);
    pulse(1'b0, 1'b0, 1'b1);
    chk16("lap_capture", bus.digits, 16'h0012);
    run(11);
    chk16("lap_frozen", bus.digits, 16'h0012);
    chk1("lap_running", bus.running, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    chk16("lap_release", bus.digits, 16'h0015);

    // pause mid-tick and resume
    run(1);
    pulse(1'b1, 1'b0, 1'b0);
    chk1("pause2_running", bus.running, 1'b0);
    run(5);
    chk16("pause_frozen", bus.digits, 16'h0015);
    pulse(1'b1, 1'b0, 1'b0);
    chk16("resume_digits", bus.digits, 16'h0015);
    run(1);
    chk16("resume_tick", bus.digits, 16'h0016);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    chk16("clr_ss_digits", bus.digits, 16'h0000);
    chk1("clr_ss_running", bus.running, 1'b0);
    run(8);
    chk16("idle_hold", bus.digits, 16'h0000);

    // asynchronous reset mid-count
    pulse(1'b1, 1'b0, 1'b0);
    run(6);
    chk16("before_rst", bus.digits, 16'h0001);
    #2;
    rst = 1'b0;
    #1;
    chk16("async_rst_digits", bus.digits, 16'h0000);
    chk1("async_rst_running", bus.running, 1'b0);
    chk1("async_rst_overflow", bus.overflow, 1'b0);
    model_reset();
    #20;
    rst = 1'b1;
    run(10);
    chk16("post_rst_idle", bus.digits, 16'h0000);
    chk1("post_rst_running", bus.running, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    run(4);
    chk16("post_rst_count", bus.digits, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
